// File: rtl/slave_out_port_burst_if.sv
// Bus bundle between the serial burst transmitter and its source / master side.
// The slave modport is the transmitter's view; master is the driver/observer's view.
interface slave_out_port_burst_if #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 16
);
    localparam int BLW = $clog2(MAX_BURST);

    logic                  master_ready;
    logic                  data_ready;
    logic [DATA_WIDTH-1:0] datain;
    logic [BLW-1:0]        burst_len;
    logic                  abort;
    logic                  tx_data;
    logic                  slave_valid;
    logic                  slave_tx_done;
    logic                  burst_done;
    logic                  data_ack;
    logic                  busy;

    modport slave (
        input  master_ready, data_ready, datain, burst_len, abort,
        output tx_data, slave_valid, slave_tx_done, burst_done, data_ack, busy
    );

    modport master (
        output master_ready, data_ready, datain, burst_len, abort,
        input  tx_data, slave_valid, slave_tx_done, burst_done, data_ack, busy
    );
endinterface

// File: rtl/slave_out_port_burst.sv
// Slave-side serial transmitter: captures words on data_ready & master_ready and
// shifts them out one bit per clock, streaming bursts of 1..MAX_BURST words.
//
//   state | meaning
//   IDLE  | no transfer; waiting for a handshake to start a burst
//   SHIFT | a word is on tx_data, one bit per cycle
//   WAIT  | between words of a burst; next word not yet offered
module slave_out_port_burst #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 16,
    parameter int MSB_FIRST  = 0,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input logic                  clk,
    input logic                  reset,
    slave_out_port_burst_if.slave bus
);
    localparam int CW  = $clog2(DATA_WIDTH);
    localparam int BLW = $clog2(MAX_BURST);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, WAIT} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_reg_q, shift_reg_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [BLW-1:0]        words_left_q, words_left_d;
    logic                  tx_data_q, tx_data_d;
    logic                  slave_valid_q, slave_valid_d;
    logic                  slave_tx_done_q, slave_tx_done_d;
    logic                  burst_done_q, burst_done_d;
    logic                  data_ack_q, data_ack_d;
    logic                  busy_q, busy_d;

    logic                  hs;
    logic                  capture;
    logic [BLW-1:0]        words_load;
    logic [CW-1:0]         next_bit;

    assign hs = bus.data_ready & bus.master_ready;

    function automatic logic pick_bit(input logic [DATA_WIDTH-1:0] word,
                                      input logic [CW-1:0]         idx);
        if (MSB_FIRST != 0) return word[LAST_BIT - idx];
        else                return word[idx];
    endfunction

    always_comb begin
        state_d         = state_q;
        shift_reg_d     = shift_reg_q;
        bit_cnt_d       = bit_cnt_q;
        words_left_d    = words_left_q;
        tx_data_d       = IDLE_LEVEL;
        slave_valid_d   = 1'b0;
        slave_tx_done_d = 1'b0;
        burst_done_d    = 1'b0;
        data_ack_d      = 1'b0;
        capture         = 1'b0;
        words_load      = words_left_q;
        next_bit        = bit_cnt_q + 1'b1;

        if (bus.abort) begin
            state_d      = IDLE;
            bit_cnt_d    = '0;
            words_left_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hs) begin
                        capture    = 1'b1;
                        words_load = bus.burst_len;
                    end
                end
                SHIFT: begin
                    if (bit_cnt_q != LAST_BIT) begin
                        bit_cnt_d     = next_bit;
                        tx_data_d     = pick_bit(shift_reg_q, next_bit);
                        slave_valid_d = 1'b1;
                        if (next_bit == LAST_BIT) begin
                            slave_tx_done_d = 1'b1;
                            burst_done_d    = (words_left_q == '0);
                        end
                    end else if (words_left_q == '0) begin
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                    end else if (hs) begin
                        // back-to-back word: no idle cycle between words
                        capture    = 1'b1;
                        words_load = words_left_q - 1'b1;
                    end else begin
                        state_d   = WAIT;
                        bit_cnt_d = '0;
                    end
                end
                WAIT: begin
                    if (hs) begin
                        capture    = 1'b1;
                        words_load = words_left_q - 1'b1;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end
            endcase
        end

        if (capture) begin
            state_d       = SHIFT;
            shift_reg_d   = bus.datain;
            bit_cnt_d     = '0;
            words_left_d  = words_load;
            tx_data_d     = pick_bit(bus.datain, '0);
            slave_valid_d = 1'b1;
            data_ack_d    = 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            shift_reg_q     <= '0;
            bit_cnt_q       <= '0;
            words_left_q    <= '0;
            tx_data_q       <= IDLE_LEVEL;
            slave_valid_q   <= 1'b0;
            slave_tx_done_q <= 1'b0;
            burst_done_q    <= 1'b0;
            data_ack_q      <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            shift_reg_q     <= shift_reg_d;
            bit_cnt_q       <= bit_cnt_d;
            words_left_q    <= words_left_d;
            tx_data_q       <= tx_data_d;
            slave_valid_q   <= slave_valid_d;
            slave_tx_done_q <= slave_tx_done_d;
            burst_done_q    <= burst_done_d;
            data_ack_q      <= data_ack_d;
            busy_q          <= busy_d;
        end
    end

    assign bus.tx_data       = tx_data_q;
    assign bus.slave_valid   = slave_valid_q;
    assign bus.slave_tx_done = slave_tx_done_q;
    assign bus.burst_done    = burst_done_q;
    assign bus.data_ack      = data_ack_q;
    assign bus.busy          = busy_q;
endmodule

// File: tb/tb_slave_out_port_burst.sv
// Bench for slave_out_port_burst: an LSB-first and an MSB-first instance share
// one stimulus stream and are compared every cycle against a bit-queue model.
module tb_slave_out_port_burst;
    localparam int DW = 8;
    localparam int MB = 16;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    slave_out_port_burst_if #(.DATA_WIDTH(DW), .MAX_BURST(MB)) bus ();
    slave_out_port_burst_if #(.DATA_WIDTH(DW), .MAX_BURST(MB)) bus2 ();

    slave_out_port_burst #(.DATA_WIDTH(DW), .MAX_BURST(MB), .MSB_FIRST(0), .IDLE_LEVEL(1'b0))
        dut_lsb (.clk(clk), .reset(reset), .bus(bus));
    slave_out_port_burst #(.DATA_WIDTH(DW), .MAX_BURST(MB), .MSB_FIRST(1), .IDLE_LEVEL(1'b0))
        dut_msb (.clk(clk), .reset(reset), .bus(bus2));

    assign bus2.master_ready = bus.master_ready;
    assign bus2.data_ready   = bus.data_ready;
    assign bus2.datain       = bus.datain;
    assign bus2.burst_len    = bus.burst_len;
    assign bus2.abort        = bus.abort;

    wire [5:0] obs1 = {bus.tx_data, bus.slave_valid, bus.slave_tx_done,
                       bus.burst_done, bus.data_ack, bus.busy};
    wire [5:0] obs2 = {bus2.tx_data, bus2.slave_valid, bus2.slave_tx_done,
                       bus2.burst_done, bus2.data_ack, bus2.busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: each captured word becomes a queue of bits in send order;
    // one bit leaves the queue per cycle, and the last one carries the done pulses.
    bit   mq1[$];
    bit   mq2[$];
    int   m_words = 0;
    bit   m_show  = 1'b0;
    bit   m_wait  = 1'b0;
    logic [5:0] e1 = '0;
    logic [5:0] e2 = '0;

    always @(posedge clk or negedge reset) begin : model
        bit hs, cap, t1, t2, v, dn, bd, ak;
        int nw;
        if (!reset) begin
            mq1.delete(); mq2.delete();
            m_words = 0; m_show = 1'b0; m_wait = 1'b0;
            e1 = '0; e2 = '0;
        end else begin
            hs = bus.data_ready & bus.master_ready;
            cap = 0; nw = 0; t1 = 0; t2 = 0; v = 0; dn = 0; bd = 0; ak = 0;
            if (bus.abort) begin
                mq1.delete(); mq2.delete();
                m_words = 0; m_show = 1'b0; m_wait = 1'b0;
            end else if (m_show && mq1.size() != 0) begin
                t1 = mq1.pop_front();
                t2 = mq2.pop_front();
                v  = 1'b1;
                dn = (mq1.size() == 0);
                bd = dn && (m_words == 0);
            end else if (m_show || m_wait) begin
                if (m_show && m_words == 0) m_show = 1'b0;
                else if (hs) begin cap = 1'b1; nw = m_words - 1; end
                else begin m_show = 1'b0; m_wait = 1'b1; end
            end else if (hs) begin
                cap = 1'b1;
                nw  = int'(bus.burst_len);
            end
            if (cap) begin
                for (int i = 0; i < DW; i++) begin
                    mq1.push_back(bus.datain[i]);
                    mq2.push_back(bus.datain[DW-1-i]);
                end
                m_words = nw; m_show = 1'b1; m_wait = 1'b0;
                t1 = mq1.pop_front();
                t2 = mq2.pop_front();
                v = 1'b1; ak = 1'b1;
            end
            e1 = {t1, v, dn, bd, ak, m_show | m_wait};
            e2 = {t2, v, dn, bd, ak, m_show | m_wait};
        end
    end

    task automatic drive_idle();
        bus.master_ready = 1'b1;
        bus.data_ready   = 1'b0;
        bus.datain       = '0;
        bus.burst_len    = '0;
        bus.abort        = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        total++; if (obs1 !== 6'b0) begin bad++; $display("FAIL reset_lsb dut=%b want=000000", obs1); end
        total++; if (obs2 !== 6'b0) begin bad++; $display("FAIL reset_msb dut=%b want=000000", obs2); end
        @(negedge clk);
        #2 reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++; if (obs1 !== 6'b0) begin bad++; $display("FAIL idle_after_reset c=%0d dut=%b want=000000", c, obs1); end
            total++; if (obs2 !== e2) begin bad++; $display("FAIL idle_after_reset_msb c=%0d dut=%b model=%b", c, obs2, e2); end
        end
    endtask

    task automatic test_single_word();
        logic [7:0] s1, s2;
        int nv1 = 0, nv2 = 0, acks = 0, dones = 0, bds = 0, done_at = 0, bd_at = 0;
        s1 = '0; s2 = '0;
        bus.data_ready = 1'b1; bus.datain = 8'h35; bus.burst_len = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            total++; if (obs1 !== e1) begin bad++; $display("FAIL single_lsb c=%0d dut=%b model=%b", c, obs1, e1); end
            total++; if (obs2 !== e2) begin bad++; $display("FAIL single_msb c=%0d dut=%b model=%b", c, obs2, e2); end
            if (bus.slave_valid)  begin s1 = {bus.tx_data, s1[7:1]}; nv1++; end
            if (bus2.slave_valid) begin s2 = {s2[6:0], bus2.tx_data}; nv2++; end
            if (bus.data_ack) acks++;
            if (bus.slave_tx_done) begin dones++; done_at = nv1; end
            if (bus.burst_done) begin bds++; bd_at = nv1; end
            if (c == 0) begin bus.data_ready = 1'b0; bus.datain = 8'hCA; end
        end
        total++; if (s1 !== 8'h35) begin bad++; $display("FAIL single_lsb_bits got=%h want=35", s1); end
        total++; if (s2 !== 8'h35) begin bad++; $display("FAIL single_msb_bits got=%h want=35", s2); end
        total++; if (nv1 != 8 || nv2 != 8) begin bad++; $display("FAIL single_valid_len got=%0d/%0d want=8", nv1, nv2); end
        total++; if (acks != 1) begin bad++; $display("FAIL single_acks got=%0d want=1", acks); end
        total++; if (dones != 1 || done_at != 8) begin bad++; $display("FAIL single_done got=%0d@%0d want=1@8", dones, done_at); end
        total++; if (bds != 1 || bd_at != 8) begin bad++; $display("FAIL single_bdone got=%0d@%0d want=1@8", bds, bd_at); end
    endtask

    task automatic test_burst_stream();
        logic [7:0]  w[3];
        logic [23:0] st;
        int k = 0, nv = 0, run = 0, maxrun = 0, acks = 0, dones = 0, bds = 0, bd_at = 0;
        w[0] = 8'h01; w[1] = 8'h80; w[2] = 8'hFF; st = '0;
        bus.data_ready = 1'b1; bus.datain = w[0]; bus.burst_len = 4'd2;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            total++; if (obs1 !== e1) begin bad++; $display("FAIL burst_lsb c=%0d dut=%b model=%b", c, obs1, e1); end
            total++; if (obs2 !== e2) begin bad++; $display("FAIL burst_msb c=%0d dut=%b model=%b", c, obs2, e2); end
            if (bus.slave_valid) begin st = {bus.tx_data, st[23:1]}; nv++; run++; end
            else run = 0;
            if (run > maxrun) maxrun = run;
            if (bus.slave_tx_done) dones++;
            if (bus.burst_done) begin bds++; bd_at = nv; end
            if (bus.data_ack) begin
                acks++; k++;
                if (k < 3) bus.datain = w[k];
                else begin bus.data_ready = 1'b0; bus.datain = 8'h5C; end
            end
        end
        total++; if (st !== 24'hFF8001) begin bad++; $display("FAIL burst_bits got=%h want=ff8001", st); end
        total++; if (maxrun != 24) begin bad++; $display("FAIL burst_contig got=%0d want=24", maxrun); end
        total++; if (acks != 3 || dones != 3) begin bad++; $display("FAIL burst_counts acks=%0d dones=%0d want=3/3", acks, dones); end
        total++; if (bds != 1 || bd_at != 24) begin bad++; $display("FAIL burst_bdone got=%0d@%0d want=1@24", bds, bd_at); end
    endtask

    task automatic test_max_burst();
        int nv = 0, run = 0, maxrun = 0, acks = 0, bds = 0, bd_at = 0;
        bus.data_ready = 1'b1; bus.datain = 8'($urandom); bus.burst_len = 4'd15;
        for (int c = 0; c < 140; c++) begin
            @(negedge clk);
            total++; if (obs1 !== e1) begin bad++; $display("FAIL maxb_lsb c=%0d dut=%b model=%b", c, obs1, e1); end
            total++; if (obs2 !== e2) begin bad++; $display("FAIL maxb_msb c=%0d dut=%b model=%b", c, obs2, e2); end
            if (bus.slave_valid) begin nv++; run++; end
            else run = 0;
            if (run > maxrun) maxrun = run;
            if (bus.burst_done) begin bds++; bd_at = nv; end
            if (bus.data_ack) begin
                acks++;
                bus.datain = 8'($urandom);
                if (acks == 16) bus.data_ready = 1'b0;
            end
        end
        total++; if (acks != 16 || maxrun != 128) begin bad++; $display("FAIL maxb_len acks=%0d run=%0d want=16/128", acks, maxrun); end
        total++; if (bds != 1 || bd_at != 128) begin bad++; $display("FAIL maxb_bdone got=%0d@%0d want=1@128", bds, bd_at); end
    endtask

    task automatic test_wait_stall();
        logic [15:0] st;
        logic gap_tx = 1'b0;
        bit   resumed = 1'b0;
        int   gap = 0, acks = 0, dones = 0, bds = 0;
        st = '0;
        bus.data_ready = 1'b1; bus.datain = 8'hA5; bus.burst_len = 4'd1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            total++; if (obs1 !== e1) begin bad++; $display("FAIL wait_lsb c=%0d dut=%b model=%b", c, obs1, e1); end
            total++; if (obs2 !== e2) begin bad++; $display("FAIL wait_msb c=%0d dut=%b model=%b", c, obs2, e2); end
            if (bus.slave_valid) st = {bus.tx_data, st[15:1]};
            if (bus.busy && !bus.slave_valid) begin gap++; gap_tx = gap_tx | bus.tx_data; end
            if (bus.slave_tx_done) dones++;
            if (bus.burst_done) bds++;
            if (bus.data_ack) begin acks++; bus.data_ready = 1'b0; bus.datain = 8'($urandom); end
            if (gap == 3 && !resumed) begin bus.data_ready = 1'b1; bus.datain = 8'h3C; resumed = 1'b1; end
        end
        total++; if (gap != 3) begin bad++; $display("FAIL wait_gap got=%0d want=3", gap); end
        total++; if (gap_tx !== 1'b0) begin bad++; $display("FAIL wait_idle_level got=%b want=0", gap_tx); end
        total++; if (st !== 16'h3CA5) begin bad++; $display("FAIL wait_bits got=%h want=3ca5", st); end
        total++; if (acks != 2 || dones != 2 || bds != 1) begin bad++; $display("FAIL wait_counts acks=%0d dones=%0d bds=%0d want=2/2/1", acks, dones, bds); end
    endtask

    task automatic test_abort();
        logic [7:0] st;
        bit aborted = 1'b0, checked = 1'b0;
        int nv = 0, dones = 0, bds = 0, acks = 0;
        bus.data_ready = 1'b1; bus.datain = 8'h5A; bus.burst_len = 4'd3;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            total++; if (obs1 !== e1) begin bad++; $display("FAIL abort_lsb c=%0d dut=%b model=%b", c, obs1, e1); end
            total++; if (obs2 !== e2) begin bad++; $display("FAIL abort_msb c=%0d dut=%b model=%b", c, obs2, e2); end
            if (bus.slave_valid) nv++;
            if (bus.slave_tx_done) dones++;
            if (bus.burst_done) bds++;
            if (c == 0) bus.data_ready = 1'b0;
            if (aborted && !checked) begin
                total++; if (bus.slave_valid !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL abort_idle valid=%b busy=%b want=0/0", bus.slave_valid, bus.busy); end
                checked = 1'b1; bus.abort = 1'b0;
            end
            if (bus.slave_valid && nv == 5 && !aborted) begin bus.abort = 1'b1; aborted = 1'b1; end
        end
        total++; if (dones != 0 || bds != 0) begin bad++; $display("FAIL abort_no_done dones=%0d bds=%0d want=0/0", dones, bds); end
        st = '0; dones = 0; bds = 0;
        bus.data_ready = 1'b1; bus.datain = 8'hC3; bus.burst_len = 4'd0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            total++; if (obs1 !== e1) begin bad++; $display("FAIL fresh_lsb c=%0d dut=%b model=%b", c, obs1, e1); end
            if (bus.slave_valid) st = {bus.tx_data, st[7:1]};
            if (bus.slave_tx_done) dones++;
            if (bus.burst_done) bds++;
            if (bus.data_ack) acks++;
            if (c == 0) bus.data_ready = 1'b0;
        end
        total++; if (st !== 8'hC3 || acks != 1) begin bad++; $display("FAIL fresh_word bits=%h acks=%0d want=c3/1", st, acks); end
        total++; if (dones != 1 || bds != 1 || bus.busy !== 1'b0) begin bad++; $display("FAIL fresh_done dones=%0d bds=%0d busy=%b want=1/1/0", dones, bds, bus.busy); end
    endtask

    task automatic test_reset_mid_burst();
        bus.data_ready = 1'b1; bus.datain = 8'($urandom); bus.burst_len = 4'd3;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            total++; if (obs1 !== e1) begin bad++; $display("FAIL prereset_lsb c=%0d dut=%b model=%b", c, obs1, e1); end
        end
        #2 reset = 1'b0;
        #1;
        total++; if (obs1 !== 6'b0) begin bad++; $display("FAIL reset_async_lsb dut=%b want=000000", obs1); end
        total++; if (obs2 !== 6'b0) begin bad++; $display("FAIL reset_async_msb dut=%b want=000000", obs2); end
        @(negedge clk);
        bus.data_ready = 1'b0;
        #2 reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++; if (obs1 !== 6'b0) begin bad++; $display("FAIL post_release_idle c=%0d dut=%b want=000000", c, obs1); end
        end
        bus.data_ready = 1'b1; bus.datain = 8'h96; bus.burst_len = 4'd0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            total++; if (obs1 !== e1) begin bad++; $display("FAIL post_reset_lsb c=%0d dut=%b model=%b", c, obs1, e1); end
            total++; if (obs2 !== e2) begin bad++; $display("FAIL post_reset_msb c=%0d dut=%b model=%b", c, obs2, e2); end
            if (c == 0) bus.data_ready = 1'b0;
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            total++; if (obs1 !== e1) begin bad++; $display("FAIL random_lsb c=%0d dut=%b model=%b", c, obs1, e1); end
            total++; if (obs2 !== e2) begin bad++; $display("FAIL random_msb c=%0d dut=%b model=%b", c, obs2, e2); end
            bus.master_ready = ($urandom_range(0, 9) != 0);
            bus.data_ready   = ($urandom_range(0, 3) != 0);
            bus.datain       = 8'($urandom);
            bus.burst_len    = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom);
            bus.abort        = ($urandom_range(0, 149) == 0);
        end
        drive_idle();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        drive_idle();
        test_reset();
        test_single_word();
        test_burst_stream();
        test_max_burst();
        test_wait_stall();
        test_abort();
        test_reset_mid_burst();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
